// File: rtl/proc_test_pkg.sv
// Shared state encodings and default widths for the processor load/run/dump sequencer.
package proc_test_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefAddrW = 8;
  localparam int unsigned DefCntW  = 16;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StDump,
    StDone
  } seq_state_e;

  typedef enum logic [1:0] {
    RdIdle,
    RdIssue,
    RdCapture,
    RdPresent
  } rd_state_e;

endpackage

// File: rtl/seq_dump_reader.sv
// Walks every RAM address in order, captures the read data one cycle later and holds it
// on a valid/ready stream until the consumer accepts it.
module seq_dump_reader
  import proc_test_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              dump_ready_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic [ADDR_W-1:0] dump_addr_o,
  output logic              dump_valid_o,
  output logic              last_o
);

  localparam logic [ADDR_W:0] LastIdx = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] IdxOne  = {{ADDR_W{1'b0}}, 1'b1};

  rd_state_e         rd_state_d, rd_state_q;
  logic [ADDR_W:0]   idx_d, idx_q;
  logic [DATA_W-1:0] data_d, data_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic              valid_d, valid_q;
  logic              accept;

  assign accept = valid_q & dump_ready_i;

  always_comb begin
    rd_state_d = rd_state_q;
    idx_d      = idx_q;
    data_d     = data_q;
    addr_d     = addr_q;
    valid_d    = valid_q;
    last_o     = 1'b0;
    unique case (rd_state_q)
      RdIdle: begin
        if (start_i) begin
          rd_state_d = RdIssue;
          idx_d      = '0;
        end
      end
      RdIssue: rd_state_d = RdCapture;
      // Read data for the address issued last cycle is on mem_rdata_i now.
      RdCapture: begin
        data_d     = mem_rdata_i;
        addr_d     = idx_q[ADDR_W-1:0];
        valid_d    = 1'b1;
        rd_state_d = RdPresent;
      end
      RdPresent: begin
        if (accept) begin
          valid_d = 1'b0;
          if (idx_q == LastIdx) begin
            last_o     = 1'b1;
            rd_state_d = RdIdle;
          end else begin
            idx_d      = idx_q + IdxOne;
            rd_state_d = RdIssue;
          end
        end
      end
      default: rd_state_d = RdIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_state_q <= RdIdle;
      idx_q      <= '0;
      data_q     <= '0;
      addr_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
    end
  end

  assign mem_addr_o   = idx_q[ADDR_W-1:0];
  assign dump_data_o  = data_q;
  assign dump_addr_o  = addr_q;
  assign dump_valid_o = valid_q;

endmodule

// File: rtl/proc_test_sequencer.sv
// Load/run/dump sequencer: streams a program image into RAM with the core held in reset, runs
// the core for a cycle budget, then freezes it and streams every RAM word back out.
module proc_test_sequencer
  import proc_test_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned CNT_W  = DefCntW
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [CNT_W-1:0]  RunCycles,
  input  logic [ADDR_W:0]   LoadWords,
  input  logic [DATA_W-1:0] LoadData,
  input  logic              LoadValid,
  output logic              LoadReady,
  output logic              ProcReset,
  output logic              ProcEnable,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWdata,
  input  logic [DATA_W-1:0] MemRdata,
  output logic [DATA_W-1:0] DumpData,
  output logic [ADDR_W-1:0] DumpAddr,
  output logic              DumpValid,
  input  logic              DumpReady,
  output logic              Busy,
  output logic              Done,
  output logic [CNT_W-1:0]  CycleCount
);

  localparam logic [ADDR_W:0]  DepthW  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]  LoadOne = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CntOne  = {{(CNT_W-1){1'b0}}, 1'b1};

  seq_state_e        state_d, state_q;
  logic [ADDR_W:0]   load_cnt_d, load_cnt_q;
  logic [ADDR_W:0]   load_tgt_d, load_tgt_q;
  logic [CNT_W-1:0]  budget_d, budget_q;
  logic [CNT_W-1:0]  cycle_cnt_d, cycle_cnt_q;
  logic              proc_reset_d, proc_reset_q;
  logic              proc_enable_d, proc_enable_q;
  logic              busy_d, busy_q;
  logic              done_d, done_q;

  logic              load_beat;
  logic              load_last;
  logic              run_last;
  logic              dump_start;
  logic              dump_last;
  logic [ADDR_W-1:0] rd_addr;

  assign LoadReady = (state_q == StLoad) && (load_cnt_q != load_tgt_q);
  assign load_beat = LoadReady & LoadValid;
  assign load_last = load_beat && ((load_cnt_q + LoadOne) == load_tgt_q);
  // A zero budget still spends one cycle in RUN, with the core left disabled.
  assign run_last  = (budget_q == '0) || (cycle_cnt_q == (budget_q - CntOne));

  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    load_tgt_d  = load_tgt_q;
    budget_d    = budget_q;
    cycle_cnt_d = cycle_cnt_q;
    dump_start  = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (Start) begin
          state_d     = StLoad;
          load_cnt_d  = '0;
          load_tgt_d  = (LoadWords > DepthW) ? DepthW : LoadWords;
          budget_d    = RunCycles;
          cycle_cnt_d = '0;
        end
      end
      StLoad: begin
        if (load_beat) begin
          load_cnt_d = load_cnt_q + LoadOne;
        end
        if ((load_cnt_q == load_tgt_q) || load_last) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if ((budget_q != '0) && (cycle_cnt_q != '1)) begin
          cycle_cnt_d = cycle_cnt_q + CntOne;
        end
        if (run_last) begin
          state_d    = StDump;
          dump_start = 1'b1;
        end
      end
      StDump: begin
        if (dump_last) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase

    proc_reset_d  = (state_d == StIdle) || (state_d == StLoad);
    proc_enable_d = (state_d == StRun) && (budget_d != '0);
    busy_d        = (state_d == StLoad) || (state_d == StRun) || (state_d == StDump);
    done_d        = (state_d == StDone);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q       <= StIdle;
      load_cnt_q    <= '0;
      load_tgt_q    <= '0;
      budget_q      <= '0;
      cycle_cnt_q   <= '0;
      proc_reset_q  <= 1'b1;
      proc_enable_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      load_cnt_q    <= load_cnt_d;
      load_tgt_q    <= load_tgt_d;
      budget_q      <= budget_d;
      cycle_cnt_q   <= cycle_cnt_d;
      proc_reset_q  <= proc_reset_d;
      proc_enable_q <= proc_enable_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  seq_dump_reader #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_dump_reader (
    .clk_i       (Clock),
    .rst_i       (Reset),
    .start_i     (dump_start),
    .mem_rdata_i (MemRdata),
    .dump_ready_i(DumpReady),
    .mem_addr_o  (rd_addr),
    .dump_data_o (DumpData),
    .dump_addr_o (DumpAddr),
    .dump_valid_o(DumpValid),
    .last_o      (dump_last)
  );

  // The RAM port is shared: load index while loading, reader address while dumping.
  always_comb begin
    MemWe    = load_beat;
    MemWdata = LoadData;
    MemAddr  = '0;
    if (state_q == StLoad) begin
      MemAddr = load_cnt_q[ADDR_W-1:0];
    end else if (state_q == StDump) begin
      MemAddr = rd_addr;
    end
  end

  assign ProcReset  = proc_reset_q;
  assign ProcEnable = proc_enable_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign CycleCount = cycle_cnt_q;

endmodule

// File: tb/tb_proc_test_sequencer.sv
// Randomised bench for proc_test_sequencer with a small RAM and an image-level reference model.
module tb_proc_test_sequencer;

  localparam int DW    = 32;
  localparam int AW    = 3;
  localparam int CW    = 16;
  localparam int Depth = 8;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          Start = 1'b0;
  logic [CW-1:0] RunCycles = '0;
  logic [AW:0]   LoadWords = '0;
  logic [DW-1:0] LoadData = '0;
  logic          LoadValid = 1'b0;
  logic          LoadReady, ProcReset, ProcEnable, MemWe;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemWdata;
  logic [DW-1:0] MemRdata;
  logic [DW-1:0] DumpData;
  logic [AW-1:0] DumpAddr;
  logic          DumpValid;
  logic          DumpReady = 1'b0;
  logic          Busy, Done;
  logic [CW-1:0] CycleCount;

  proc_test_sequencer #(
    .DATA_W(DW),
    .ADDR_W(AW),
    .CNT_W (CW)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Start     (Start),
    .RunCycles (RunCycles),
    .LoadWords (LoadWords),
    .LoadData  (LoadData),
    .LoadValid (LoadValid),
    .LoadReady (LoadReady),
    .ProcReset (ProcReset),
    .ProcEnable(ProcEnable),
    .MemWe     (MemWe),
    .MemAddr   (MemAddr),
    .MemWdata  (MemWdata),
    .MemRdata  (MemRdata),
    .DumpData  (DumpData),
    .DumpAddr  (DumpAddr),
    .DumpValid (DumpValid),
    .DumpReady (DumpReady),
    .Busy      (Busy),
    .Done      (Done),
    .CycleCount(CycleCount)
  );

  always #5 Clock = ~Clock;

  // Synchronous-read RAM standing in for the processor data memory.
  logic [DW-1:0] ram [Depth];
  always @(posedge Clock) begin
    if (MemWe) ram[MemAddr] <= MemWdata;
    MemRdata <= ram[MemAddr];
  end

  // Observation of the DUT interfaces, sampled mid-cycle.
  int          wr_cnt = 0, en_cnt = 0, bad_we = 0, we_outside = 0, unstable = 0;
  logic [31:0] wr_addr_q[$], wr_data_q[$], dmp_addr_q[$], dmp_data_q[$];
  logic        prev_hold = 1'b0;
  logic [DW-1:0] prev_data;
  logic [AW-1:0] prev_addr;

  always @(negedge Clock) begin
    if (MemWe) begin
      wr_cnt++;
      wr_addr_q.push_back({29'b0, MemAddr});
      wr_data_q.push_back(MemWdata);
      if (!LoadValid) bad_we++;
      if (!(Busy && ProcReset)) we_outside++;
    end
    if (ProcEnable) en_cnt++;
    if (DumpValid && DumpReady) begin
      dmp_addr_q.push_back({29'b0, DumpAddr});
      dmp_data_q.push_back(DumpData);
    end
    if (prev_hold && (!DumpValid || DumpData !== prev_data || DumpAddr !== prev_addr)) unstable++;
    prev_hold = DumpValid && !DumpReady;
    prev_data = DumpData;
    prev_addr = DumpAddr;
  end

  // Reference model: the RAM image the host has written so far.
  logic [DW-1:0] exp_mem [Depth];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic start_job(input int lw, input int rc);
    LoadWords = lw[AW:0];
    RunCycles = rc[CW-1:0];
    Start     = 1'b1;
    @(posedge Clock); #1;
    Start     = 1'b0;
  endtask

  // pat: 0 random, 1 i*3, 2 0x11*(i+1); vmode: 0 steady, 1 toggling, 2 random.
  task automatic feed_load(input int lw, input int pat, input int vmode, output int cycles);
    int k = 0;
    int guard = 0;
    int nexp = (lw > Depth) ? Depth : lw;
    logic [DW-1:0] d;
    while (ProcReset && guard < 300) begin
      d = (pat == 1) ? k * 3 : (pat == 2) ? 32'h11 * (k + 1) : $urandom;
      LoadData  = d;
      LoadValid = (vmode == 0) ? 1'b1 : (vmode == 1) ? ((guard % 2) == 0) : 1'($urandom_range(0, 1));
      @(negedge Clock);
      if (LoadValid && LoadReady) begin
        if (k < nexp) exp_mem[k] = d;
        k++;
      end
      @(posedge Clock); #1;
      guard++;
    end
    LoadValid = 1'b0;
    cycles    = guard;
    n_checks++;
    if (guard >= 300) begin
      n_fail++;
      $display("FAIL load_timeout: still in load after %0d cycles, want RUN", guard);
    end
  endtask

  // rmode: 0 always ready, 1 random ready, 2 ready with a 5-cycle stall after 3 words.
  task automatic finish_job(input int rmode);
    int guard = 0;
    int stall = 0;
    bit stalled = 1'b0;
    int base = dmp_addr_q.size();
    while (!Done && guard < 600) begin
      if (rmode == 0) DumpReady = 1'b1;
      else if (rmode == 1) DumpReady = 1'($urandom_range(0, 1));
      else begin
        if (!stalled && (dmp_addr_q.size() - base) >= 3) begin
          stalled = 1'b1;
          stall   = 5;
        end
        DumpReady = (stall == 0);
        if (stall > 0) stall--;
      end
      @(posedge Clock); #1;
      guard++;
    end
    DumpReady = 1'b0;
    n_checks++;
    if (Done !== 1'b1) begin
      n_fail++;
      $display("FAIL done_timeout: Done=%b after %0d cycles, want 1", Done, guard);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(posedge Clock);
    #1;
    n_checks++;
    if ({ProcReset, ProcEnable, LoadReady, MemWe, DumpValid, Busy, Done} !== 7'b1000000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 1000000",
               {ProcReset, ProcEnable, LoadReady, MemWe, DumpValid, Busy, Done});
    end
    n_checks++;
    if (MemAddr !== '0) begin
      n_fail++;
      $display("FAIL reset_memaddr: got %0d want 0", MemAddr);
    end
    n_checks++;
    if ({DumpData, DumpAddr} !== '0) begin
      n_fail++;
      $display("FAIL reset_dump: got data %h addr %0d want 0", DumpData, DumpAddr);
    end
    n_checks++;
    if (CycleCount !== '0) begin
      n_fail++;
      $display("FAIL reset_cyclecount: got %0d want 0", CycleCount);
    end
    Reset = 1'b0;
    @(posedge Clock); #1;
  endtask

  task automatic test_preload_dump();
    int cyc;
    int wr0 = wr_cnt;
    int en0 = en_cnt;
    int base = dmp_addr_q.size();
    start_job(8, 3);
    feed_load(8, 1, 0, cyc);
    finish_job(2);
    n_checks++;
    if (wr_cnt - wr0 !== 8) begin
      n_fail++;
      $display("FAIL preload_writes: got %0d want 8", wr_cnt - wr0);
    end
    n_checks++;
    if (en_cnt - en0 !== 3) begin
      n_fail++;
      $display("FAIL preload_enable: got %0d want 3", en_cnt - en0);
    end
    n_checks++;
    if (dmp_addr_q.size() - base !== Depth) begin
      n_fail++;
      $display("FAIL preload_dump_len: got %0d want %0d", dmp_addr_q.size() - base, Depth);
    end
    for (int i = 0; i < Depth; i++) begin
      n_checks++;
      if (base + i >= dmp_addr_q.size() || dmp_addr_q[base+i] !== i ||
          dmp_data_q[base+i] !== i * 3) begin
        n_fail++;
        $display("FAIL preload_dump_word %0d: want addr %0d data %0d", i, i, i * 3);
      end
    end
    n_checks++;
    if (unstable !== 0) begin
      n_fail++;
      $display("FAIL dump_stall_stability: got %0d changes while stalled, want 0", unstable);
    end
  endtask

  task automatic test_load_steady();
    int cyc;
    int wr0 = wr_cnt;
    int en0 = en_cnt;
    int base = dmp_addr_q.size();
    start_job(4, 37);
    feed_load(4, 2, 0, cyc);
    n_checks++;
    if (wr_cnt - wr0 !== 4 || cyc !== 4) begin
      n_fail++;
      $display("FAIL steady_writes: got %0d writes in %0d cycles want 4 in 4", wr_cnt - wr0, cyc);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (wr_addr_q[wr0+i] !== i || wr_data_q[wr0+i] !== 32'h11 * (i + 1)) begin
        n_fail++;
        $display("FAIL steady_write %0d: got addr %0d data %h want addr %0d data %h", i,
                 wr_addr_q[wr0+i], wr_data_q[wr0+i], i, 32'h11 * (i + 1));
      end
    end
    n_checks++;
    if ({ProcReset, ProcEnable, Busy} !== 3'b011) begin
      n_fail++;
      $display("FAIL steady_run_entry: got %b want 011", {ProcReset, ProcEnable, Busy});
    end
    finish_job(0);
    n_checks++;
    if (en_cnt - en0 !== 37 || CycleCount !== 37) begin
      n_fail++;
      $display("FAIL steady_run_len: got enable %0d count %0d want 37", en_cnt - en0, CycleCount);
    end
    for (int i = 0; i < Depth; i++) begin
      n_checks++;
      if (base + i >= dmp_addr_q.size() || dmp_addr_q[base+i] !== i ||
          dmp_data_q[base+i] !== exp_mem[i]) begin
        n_fail++;
        $display("FAIL steady_dump_word %0d: want data %h", i, exp_mem[i]);
      end
    end
  endtask

  task automatic test_load_toggle();
    int cyc;
    int wr0 = wr_cnt;
    int bad0 = bad_we;
    start_job(3, 2);
    feed_load(3, 0, 1, cyc);
    n_checks++;
    if (wr_cnt - wr0 !== 3 || bad_we - bad0 !== 0) begin
      n_fail++;
      $display("FAIL toggle_writes: got %0d writes %0d without valid want 3 and 0",
               wr_cnt - wr0, bad_we - bad0);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (wr_addr_q[wr0+i] !== i || wr_data_q[wr0+i] !== exp_mem[i]) begin
        n_fail++;
        $display("FAIL toggle_write %0d: got addr %0d want %0d", i, wr_addr_q[wr0+i], i);
      end
    end
    finish_job(1);
  endtask

  task automatic test_zero_run();
    int cyc;
    int en0 = en_cnt;
    int base = dmp_addr_q.size();
    start_job(2, 0);
    feed_load(2, 0, 2, cyc);
    finish_job(1);
    n_checks++;
    if (en_cnt - en0 !== 0 || CycleCount !== 0) begin
      n_fail++;
      $display("FAIL zero_run: got enable %0d count %0d want 0 and 0", en_cnt - en0, CycleCount);
    end
    for (int i = 0; i < Depth; i++) begin
      n_checks++;
      if (base + i >= dmp_addr_q.size() || dmp_addr_q[base+i] !== i ||
          dmp_data_q[base+i] !== exp_mem[i]) begin
        n_fail++;
        $display("FAIL zero_run_dump_word %0d: want data %h", i, exp_mem[i]);
      end
    end
  endtask

  task automatic test_reset_in_run();
    int cyc;
    start_job(2, 100);
    feed_load(2, 0, 0, cyc);
    repeat (9) begin
      @(posedge Clock); #1;
    end
    n_checks++;
    if ({ProcEnable, Busy, CycleCount} !== {2'b11, 16'd9}) begin
      n_fail++;
      $display("FAIL run_before_reset: got en %b busy %b count %0d want 1 1 9",
               ProcEnable, Busy, CycleCount);
    end
    Reset = 1'b1;
    @(posedge Clock); #1;
    n_checks++;
    if ({ProcReset, ProcEnable, Busy, DumpValid, Done, CycleCount} !== {5'b10000, 16'd0}) begin
      n_fail++;
      $display("FAIL reset_in_run: got rst %b en %b busy %b dv %b done %b count %0d",
               ProcReset, ProcEnable, Busy, DumpValid, Done, CycleCount);
    end
    Reset = 1'b0;
    @(posedge Clock); #1;
  endtask

  task automatic test_start_in_dump();
    int cyc;
    int g = 0;
    int wr0 = wr_cnt;
    int en0 = en_cnt;
    int base = dmp_addr_q.size();
    start_job(0, 3);
    feed_load(0, 0, 0, cyc);
    while (!DumpValid && g < 50) begin
      @(posedge Clock); #1;
      g++;
    end
    LoadWords = 4'd5;
    RunCycles = 16'd9;
    Start     = 1'b1;
    @(posedge Clock); #1;
    Start     = 1'b0;
    n_checks++;
    if ({DumpValid, ProcReset, Busy, LoadReady, ProcEnable} !== 5'b10100) begin
      n_fail++;
      $display("FAIL start_in_dump: got dv/rst/busy/ready/en %b want 10100",
               {DumpValid, ProcReset, Busy, LoadReady, ProcEnable});
    end
    finish_job(0);
    n_checks++;
    if (wr_cnt - wr0 !== 0 || en_cnt - en0 !== 3 || CycleCount !== 3) begin
      n_fail++;
      $display("FAIL start_in_dump_after: got writes %0d enable %0d count %0d want 0 3 3",
               wr_cnt - wr0, en_cnt - en0, CycleCount);
    end
    for (int i = 0; i < Depth; i++) begin
      n_checks++;
      if (base + i >= dmp_addr_q.size() || dmp_addr_q[base+i] !== i ||
          dmp_data_q[base+i] !== exp_mem[i]) begin
        n_fail++;
        $display("FAIL start_in_dump_word %0d: want data %h", i, exp_mem[i]);
      end
    end
  endtask

  task automatic test_restart_zero_load();
    int cyc;
    int wr0 = wr_cnt;
    int en0 = en_cnt;
    int base = dmp_addr_q.size();
    start_job(0, 5);
    feed_load(0, 0, 0, cyc);
    finish_job(0);
    n_checks++;
    if (cyc !== 1 || wr_cnt - wr0 !== 0) begin
      n_fail++;
      $display("FAIL restart_load: got %0d cycles %0d writes want 1 and 0", cyc, wr_cnt - wr0);
    end
    n_checks++;
    if (en_cnt - en0 !== 5 || CycleCount !== 5) begin
      n_fail++;
      $display("FAIL restart_run: got enable %0d count %0d want 5", en_cnt - en0, CycleCount);
    end
    for (int i = 0; i < Depth; i++) begin
      n_checks++;
      if (base + i >= dmp_addr_q.size() || dmp_addr_q[base+i] !== i ||
          dmp_data_q[base+i] !== exp_mem[i]) begin
        n_fail++;
        $display("FAIL restart_dump_word %0d: want data %h", i, exp_mem[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 5; it++) begin
      int cyc;
      int lw = (it == 0) ? 11 : int'($urandom_range(0, 11));
      int rc = int'($urandom_range(0, 40));
      int nexp = (lw > Depth) ? Depth : lw;
      int wr0 = wr_cnt;
      int en0 = en_cnt;
      int base = dmp_addr_q.size();
      start_job(lw, rc);
      feed_load(lw, 0, 2, cyc);
      finish_job(1);
      n_checks++;
      if (wr_cnt - wr0 !== nexp || en_cnt - en0 !== rc || CycleCount !== rc) begin
        n_fail++;
        $display("FAIL random_job %0d: got writes %0d enable %0d count %0d want %0d %0d %0d",
                 it, wr_cnt - wr0, en_cnt - en0, CycleCount, nexp, rc, rc);
      end
      for (int i = 0; i < Depth; i++) begin
        n_checks++;
        if (base + i >= dmp_addr_q.size() || dmp_addr_q[base+i] !== i ||
            dmp_data_q[base+i] !== exp_mem[i]) begin
          n_fail++;
          $display("FAIL random_dump %0d word %0d: want data %h", it, i, exp_mem[i]);
        end
      end
    end
    n_checks++;
    if (we_outside !== 0 || unstable !== 0) begin
      n_fail++;
      $display("FAIL global_rules: got %0d writes outside load %0d stall changes want 0 0",
               we_outside, unstable);
    end
  endtask

  initial begin
    test_reset();
    test_preload_dump();
    test_load_steady();
    test_load_toggle();
    test_zero_run();
    test_reset_in_run();
    test_start_in_dump();
    test_restart_zero_load();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
